// File: rtl/decoder_seq.sv
// Command-driven one-hot decoder: static DECODE, rotating WALK, CLEAR.
// Rejected commands (reserved mode, out-of-range select) raise a one-cycle err pulse.
module decoder_seq #(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic [SEL_W-1:0] i_cmd_sel,
  input  logic [SEL_W-1:0] i_cmd_len,
  output logic [OUTS-1:0]  o_out,
  output logic             o_out_valid,
  output logic             o_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WALK = 2'd2;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_WALK   = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;

  localparam logic [SEL_W:0]   OUTS_LIM = OUTS[SEL_W:0];
  localparam logic [OUTS-1:0]  ONE_OUT  = {{(OUTS-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] CNT_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] CNT_ZERO = {SEL_W{1'b0}};
  localparam logic [OUTS-1:0]  OUT_ZERO = {OUTS{1'b0}};

  logic [1:0]       r_state;
  logic [OUTS-1:0]  r_out;
  logic [SEL_W-1:0] r_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_sel_bad;
  logic [OUTS-1:0]  w_onehot;
  logic [OUTS-1:0]  w_rot;

  assign o_cmd_ready = i_en & ~i_rst & (r_state != ST_WALK);
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_sel_bad   = ({1'b0, i_cmd_sel} >= OUTS_LIM);
  assign w_onehot    = ONE_OUT << i_cmd_sel;
  assign w_rot       = {r_out[OUTS-2:0], r_out[OUTS-1]};

  // Disable masks the ports only; the internal position is kept so a walk resumes in place.
  assign o_out       = i_en ? r_out : OUT_ZERO;
  assign o_out_valid = i_en & (|r_out);
  assign o_err       = i_en & r_err;

  // Command execution and walk sequencing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_out   <= OUT_ZERO;
      r_cnt   <= CNT_ZERO;
      r_err   <= 1'b0;
    end else if (!i_en) begin
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        case (i_cmd_mode)
          MODE_DECODE, MODE_WALK: begin
            if (w_sel_bad) begin
              r_err   <= 1'b1;
              r_out   <= OUT_ZERO;
              r_cnt   <= CNT_ZERO;
              r_state <= ST_IDLE;
            end else if (i_cmd_mode == MODE_WALK) begin
              r_out   <= w_onehot;
              r_cnt   <= i_cmd_len;
              r_state <= ST_WALK;
            end else begin
              r_out   <= w_onehot;
              r_state <= ST_HOLD;
            end
          end
          MODE_CLEAR: begin
            r_out   <= OUT_ZERO;
            r_cnt   <= CNT_ZERO;
            r_state <= ST_IDLE;
          end
          default: begin
            r_err <= 1'b1;
          end
        endcase
      end else if (r_state == ST_WALK) begin
        if (r_cnt != CNT_ZERO) begin
          r_out <= w_rot;
          r_cnt <= r_cnt - CNT_ONE;
        end else begin
          r_out   <= OUT_ZERO;
          r_state <= ST_IDLE;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: an OUTS=8 instance driven from a vector table and
// hand sequences, plus an OUTS=6 instance for range rejection and short-ring wrap.
module tb_decoder_seq;

  typedef struct {
    logic       en;
    logic       valid;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [2:0] len;
    logic [7:0] e_out;
    logic       e_valid;
    logic       e_ready;
    logic       e_err;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en8, v8, rdy8, ov8, err8;
  logic [1:0] mode8;
  logic [2:0] sel8, len8;
  logic [7:0] out8;
  logic       en6, v6, rdy6, ov6, err6;
  logic [1:0] mode6;
  logic [2:0] sel6, len6;
  logic [5:0] out6;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  decoder_seq #(.SEL_W(3), .OUTS(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en8), .i_cmd_valid(v8), .o_cmd_ready(rdy8),
    .i_cmd_mode(mode8), .i_cmd_sel(sel8), .i_cmd_len(len8),
    .o_out(out8), .o_out_valid(ov8), .o_err(err8)
  );

  decoder_seq #(.SEL_W(3), .OUTS(6)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_en(en6), .i_cmd_valid(v6), .o_cmd_ready(rdy6),
    .i_cmd_mode(mode6), .i_cmd_sel(sel6), .i_cmd_len(len6),
    .o_out(out6), .o_out_valid(ov6), .o_err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic valid, input logic [1:0] mode,
                              input logic [2:0] sel, input logic [2:0] len, input logic [7:0] eo,
                              input logic ev, input logic er, input logic ee);
    vec_t v;
    v.en = en; v.valid = valid; v.mode = mode; v.sel = sel; v.len = len;
    v.e_out = eo; v.e_valid = ev; v.e_ready = er; v.e_err = ee;
    return v;
  endfunction

  // Called at a falling edge: drive one cycle of inputs, check outputs after the rising edge.
  task automatic run_vec(input bit six, input vec_t v, input string tag);
    if (six) begin
      en6 = v.en; v6 = v.valid; mode6 = v.mode; sel6 = v.sel; len6 = v.len;
      en8 = 1'b1; v8 = 1'b0;
    end else begin
      en8 = v.en; v8 = v.valid; mode8 = v.mode; sel8 = v.sel; len8 = v.len;
      en6 = 1'b1; v6 = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (six) begin
      check({tag, ".out"},   {2'b00, out6}, v.e_out);
      check({tag, ".valid"}, {7'd0, ov6},   {7'd0, v.e_valid});
      check({tag, ".ready"}, {7'd0, rdy6},  {7'd0, v.e_ready});
      check({tag, ".err"},   {7'd0, err6},  {7'd0, v.e_err});
    end else begin
      check({tag, ".out"},   out8,          v.e_out);
      check({tag, ".valid"}, {7'd0, ov8},   {7'd0, v.e_valid});
      check({tag, ".ready"}, {7'd0, rdy8},  {7'd0, v.e_ready});
      check({tag, ".err"},   {7'd0, err8},  {7'd0, v.e_err});
    end
  endtask

  // One-hot and valid-consistency invariants on both instances every cycle.
  always @(negedge clk) begin
    check("inv8.pop",   {7'd0, ($countones(out8) <= 1)}, 8'd1);
    check("inv8.valid", {7'd0, ov8},  {7'd0, (out8 != 8'd0)});
    check("inv6.pop",   {7'd0, ($countones(out6) <= 1)}, 8'd1);
    check("inv6.valid", {7'd0, ov6},  {7'd0, (out6 != 6'd0)});
  end

  initial begin
    rst = 1'b1;
    en8 = 1'b1; v8 = 1'b0; mode8 = 2'b00; sel8 = 3'd0; len8 = 3'd0;
    en6 = 1'b1; v6 = 1'b0; mode6 = 2'b00; sel6 = 3'd0; len6 = 3'd0;
    #2;
    check("rst.out",   out8,         8'h00);
    check("rst.valid", {7'd0, ov8},  8'd0);
    check("rst.ready", {7'd0, rdy8}, 8'd0);
    check("rst.err",   {7'd0, err8}, 8'd0);
    check("rst.ready6", {7'd0, rdy6}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // en, valid, mode, sel, len -> out, valid, ready, err
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd5, 3'd0, 8'h20, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h20, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b01, 3'd6, 3'd3, 8'h40, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h80, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h02, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd3, 3'd0, 8'h08, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b11, 3'd1, 3'd2, 8'h08, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h08, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b01, 3'd7, 3'd0, 8'h80, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b01, 3'd7, 3'd1, 8'h80, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd2, 3'd0, 8'h04, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 2'b00, 3'd6, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h04, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b01, 3'd1, 3'd1, 8'h02, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 8'h04, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h01, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++)
      run_vec(1'b0, tbl[i], $sformatf("tbl%0d", i));

    // Walk with a two-cycle enable stall after 0x04.
    run_vec(1'b0, mk(1'b1, 1'b1, 2'b01, 3'd0, 3'd7, 8'h01, 1'b1, 1'b0, 1'b0), "stall.w0");
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h02, 1'b1, 1'b0, 1'b0), "stall.w1");
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h04, 1'b1, 1'b0, 1'b0), "stall.w2");
    run_vec(1'b0, mk(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0), "stall.s0");
    run_vec(1'b0, mk(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0), "stall.s1");
    en8 = 1'b1;
    #1;
    check("stall.resume_out", out8, 8'h04);
    for (int k = 3; k < 8; k++)
      run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h01 << k, 1'b1, 1'b0, 1'b0),
              $sformatf("stall.w%0d", k));
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "stall.end");

    // Asynchronous reset between edges in the middle of a walk.
    run_vec(1'b0, mk(1'b1, 1'b1, 2'b01, 3'd2, 3'd5, 8'h04, 1'b1, 1'b0, 1'b0), "arst.w0");
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h08, 1'b1, 1'b0, 1'b0), "arst.w1");
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h10, 1'b1, 1'b0, 1'b0), "arst.w2");
    #2 rst = 1'b1;
    #1;
    check("arst.out",   out8,         8'h00);
    check("arst.valid", {7'd0, ov8},  8'd0);
    check("arst.ready", {7'd0, rdy8}, 8'd0);
    check("arst.err",   {7'd0, err8}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(1'b0, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "arst.idle");
    run_vec(1'b0, mk(1'b1, 1'b1, 2'b00, 3'd1, 3'd0, 8'h02, 1'b1, 1'b1, 1'b0), "arst.dec1");

    // OUTS=6: out-of-range select, reserved mode from HOLD, wrap of the short ring.
    run_vec(1'b1, mk(1'b1, 1'b1, 2'b00, 3'd6, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1), "o6.bad");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "o6.bad_after");
    run_vec(1'b1, mk(1'b1, 1'b1, 2'b00, 3'd5, 3'd0, 8'h20, 1'b1, 1'b1, 1'b0), "o6.dec5");
    run_vec(1'b1, mk(1'b1, 1'b1, 2'b11, 3'd0, 3'd0, 8'h20, 1'b1, 1'b1, 1'b1), "o6.rsvd");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h20, 1'b1, 1'b1, 1'b0), "o6.rsvd_after");
    run_vec(1'b1, mk(1'b1, 1'b1, 2'b01, 3'd4, 3'd2, 8'h10, 1'b1, 1'b0, 1'b0), "o6.w0");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h20, 1'b1, 1'b0, 1'b0), "o6.w1");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0), "o6.w2");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "o6.wend");
    run_vec(1'b1, mk(1'b1, 1'b1, 2'b01, 3'd7, 3'd1, 8'h00, 1'b0, 1'b1, 1'b1), "o6.badwalk");
    run_vec(1'b1, mk(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "o6.final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
